// File: rtl/dp_app_ram_arb_if.sv
// Application RAM access port: one request/ack handshake with a 32-bit data path.
// The mst side drives an access and receives ack/dout one cycle later.
// The slv side accepts the access and returns ack/dout.
interface prt_dp_app_ram_if #(
  parameter int P_ADR = 10
);
  logic             req;
  logic             wr;
  logic [P_ADR-1:0] adr;
  logic [31:0]      din;
  logic [3:0]       msk;
  logic             ack;
  logic [31:0]      dout;

  modport mst (
    output req, wr, adr, din, msk,
    input  ack, dout
  );

  modport slv (
    input  req, wr, adr, din, msk,
    output ack, dout
  );
endinterface

// File: rtl/dp_app_ram_arb.sv
// Two-requester arbiter sharing one application RAM port (round-robin or fixed priority).
// Latency: grant is combinational in the request cycle; ack/dout return one cycle later.
// Backpressure: a losing requester simply holds req; the RAM accepts one access per cycle.
module dp_app_ram_arb #(
  parameter int P_ADR        = 10,
  parameter bit P_FIXED_PRIO = 1'b0
) (
  input  wire logic      CLK_IN,
  input  wire logic      RST_IN,
  prt_dp_app_ram_if.slv  REQ0_IF,
  prt_dp_app_ram_if.slv  REQ1_IF,
  prt_dp_app_ram_if.mst  RAM_IF
);

  // Access issued last cycle, whose ack/dout arrive from the RAM this cycle.
  logic             inflight_vld;
  logic             inflight_id;
  // Last winner; the round-robin pointer. Resets to 1 so requester 0 wins the first tie.
  logic             last_id;

  logic             ack0_cyc;
  logic             ack1_cyc;
  logic             elig0;
  logic             elig1;
  logic             gnt_vld;
  logic             gnt_id;

  logic             mux_req;
  logic             mux_wr;
  logic [P_ADR-1:0] mux_adr;
  logic [31:0]      mux_din;
  logic [3:0]       mux_msk;

  // A requester being acked this cycle still holds its old req; mask it out.
  // Nothing here depends on RAM_IF.ack/dout, so no path from the RAM back to RAM_IF.req.
  always_comb begin
    ack0_cyc = inflight_vld & ~inflight_id;
    ack1_cyc = inflight_vld &  inflight_id;
    elig0    = RST_IN & REQ0_IF.req & ~ack0_cyc;
    elig1    = RST_IN & REQ1_IF.req & ~ack1_cyc;
    gnt_vld  = elig0 | elig1;
    if (elig0 && elig1) begin
      gnt_id = P_FIXED_PRIO ? 1'b0 : ~last_id;
    end else begin
      gnt_id = elig1;
    end
  end

  // Route the winner onto the RAM port; everything is zero without a grant.
  always_comb begin
    mux_req = 1'b0;
    mux_wr  = 1'b0;
    mux_adr = '0;
    mux_din = '0;
    mux_msk = '0;
    if (gnt_vld) begin
      mux_req = 1'b1;
      if (gnt_id) begin
        mux_wr  = REQ1_IF.wr;
        mux_adr = REQ1_IF.adr;
        mux_din = REQ1_IF.din;
        mux_msk = REQ1_IF.wr ? REQ1_IF.msk : 4'b0000;
      end else begin
        mux_wr  = REQ0_IF.wr;
        mux_adr = REQ0_IF.adr;
        mux_din = REQ0_IF.din;
        mux_msk = REQ0_IF.wr ? REQ0_IF.msk : 4'b0000;
      end
    end
  end

  assign RAM_IF.req = mux_req;
  assign RAM_IF.wr  = mux_wr;
  assign RAM_IF.adr = mux_adr;
  assign RAM_IF.din = mux_din;
  assign RAM_IF.msk = mux_msk;

  // Track the in-flight access and the round-robin pointer.
  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      inflight_vld <= 1'b0;
      inflight_id  <= 1'b0;
      last_id      <= 1'b1;
    end else begin
      inflight_vld <= gnt_vld;
      if (gnt_vld) begin
        inflight_id <= gnt_id;
        last_id     <= gnt_id;
      end
    end
  end

  // Return path: only the owner of the in-flight access sees ack and data.
  // A missing RAM ack drops the access silently.
  assign REQ0_IF.ack  = RST_IN & ack0_cyc & RAM_IF.ack;
  assign REQ1_IF.ack  = RST_IN & ack1_cyc & RAM_IF.ack;
  assign REQ0_IF.dout = (RST_IN & ack0_cyc) ? RAM_IF.dout : 32'h0;
  assign REQ1_IF.dout = (RST_IN & ack1_cyc) ? RAM_IF.dout : 32'h0;

  // The RAM always acknowledges in the cycle after an access.
  a_no_lost_ack : assert property (@(posedge CLK_IN) disable iff (!RST_IN)
    inflight_vld |-> RAM_IF.ack);

endmodule
